// File: rtl/spike_train_decoder.sv
// rtl/spike_train_decoder.sv - threshold spike detector with ISI, windowed rate and burst tracking
module spike_train_decoder #(
  parameter logic signed [7:0] THRESH     = 8'sd30,
  parameter logic signed [7:0] REARM      = -8'sd40,
  parameter int                WINDOW_LEN = 1024,
  parameter int                BURST_ISI  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              v_valid,
  input  logic signed [7:0] v_in,
  output logic              spike,
  output logic [15:0]       isi,
  output logic              isi_valid,
  output logic [7:0]        rate,
  output logic              rate_valid,
  output logic              burst
);

  localparam logic [0:0]  ARMED    = 1'b0;
  localparam logic [0:0]  FIRED    = 1'b1;
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_LEN - 1);
  localparam logic [15:0] BURST_L  = 16'(BURST_ISI);

  logic [0:0]  state;
  logic [15:0] isi_cnt;
  logic [15:0] win_cnt;
  logic [7:0]  win_spk;
  logic [1:0]  run_cnt;
  logic        first_spike;

  logic        accept;
  logic        spike_det;
  logic        win_end;
  logic [15:0] isi_inc;
  logic [7:0]  spk_sum;
  logic [1:0]  run_inc;

  always_comb begin
    accept    = ena & v_valid;
    spike_det = accept && (state == ARMED) && (v_in >= THRESH);
    win_end   = accept && (win_cnt == WIN_LAST);
    // Interval includes the current sample, so it is the saturated increment.
    isi_inc   = (isi_cnt == 16'hFFFF) ? isi_cnt : isi_cnt + 16'd1;
    spk_sum   = (spike_det && win_spk != 8'hFF) ? win_spk + 8'd1 : win_spk;
    run_inc   = (run_cnt == 2'd3) ? run_cnt : run_cnt + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARMED;
      isi_cnt     <= '0;
      win_cnt     <= '0;
      win_spk     <= '0;
      run_cnt     <= '0;
      first_spike <= 1'b1;
      spike       <= 1'b0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      rate        <= '0;
      rate_valid  <= 1'b0;
      burst       <= 1'b0;
    end else begin
      spike      <= 1'b0;
      isi_valid  <= 1'b0;
      rate_valid <= 1'b0;
      if (accept) begin
        if (spike_det)
          state <= FIRED;
        else if (state == FIRED && v_in <= REARM)
          state <= ARMED;

        win_cnt <= win_end ? 16'd0 : win_cnt + 16'd1;
        if (win_end) begin
          rate       <= spk_sum;
          rate_valid <= 1'b1;
          win_spk    <= '0;
        end else begin
          win_spk <= spk_sum;
        end

        if (spike_det) begin
          spike       <= 1'b1;
          isi_cnt     <= '0;
          first_spike <= 1'b0;
          if (!first_spike) begin
            isi       <= isi_inc;
            isi_valid <= 1'b1;
            if (isi_inc < BURST_L) begin
              run_cnt <= run_inc;
              burst   <= (run_inc == 2'd3);
            end else begin
              run_cnt <= '0;
              burst   <= 1'b0;
            end
          end
        end else begin
          isi_cnt <= isi_inc;
          // A long silence ends the burst even without a closing spike.
          if (isi_inc == BURST_L) begin
            run_cnt <= '0;
            burst   <= 1'b0;
          end
        end
      end
    end
  end

endmodule
